axis_uart_rx: RTL and testbench
===============================

Name: axis_uart_rx

Overview:
UART receiver that deserialises DATA_BYTE consecutive UART characters into one AXI-Stream word and presents it on an AXI-Stream master interface. It is the receive counterpart of the team's AXI-Stream UART transmitter and uses the same frame format: start bit, DATA_BITS data bits LSB first, one parity bit, STOP_BITS stop bits, with the most significant byte first. It sits between the board RX pin and the downstream AXI-Stream fabric.

Parameters:
CLOCK, 100_000_000, aclk frequency in Hz.
BAUD_RATE, 115_200, line rate; COUNT_SPEED = CLOCK/BAUD_RATE clocks per bit.
AXI_DATA_WIDTH, 32, tdata width; must be a multiple of DATA_BITS.
DATA_BITS, 8, data bits per character; DATA_BYTE = AXI_DATA_WIDTH/DATA_BITS.
PARITY_BITS, 1, 1 = even parity (parity bit = XOR of data), 0 = odd parity (parity bit = XNOR of data).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous active-low reset.
uart_rx  in  1  asynchronous serial line, idle high.
rx_done  out  1  one-cycle pulse when a complete word is loaded into the output register.
parity_err  out  1  one-cycle pulse when a character fails the parity check.
frame_err  out  1  one-cycle pulse when any stop bit is sampled low.
overrun  out  1  one-cycle pulse when a completed word is dropped because the previous word is still pending.
m_axis  axis_if.m_axis  —  tdata[AXI_DATA_WIDTH], tvalid, tready.

Behaviour:
- Reset is aresetn, synchronous, active-low, on clock aclk. On reset: tvalid=0, tdata=0, rx_done/parity_err/frame_err/overrun=0, FSM=IDLE, all counters=0, any partial word discarded. Reset mid-frame behaves identically.
- uart_rx passes through a 2-flop synchroniser. Reset value of the synchroniser is 1. All sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge; count_baud cleared.
  - START: at count_baud = COUNT_SPEED/2-1 (mid start bit), sample the line. If high, treat it as a glitch: return to IDLE, byte count unchanged. If low, go to DATA with count_baud=0.
  - DATA: sample at each count_baud = COUNT_SPEED-1 (mid-bit). Bit i goes to shift position i (LSB first). After DATA_BITS samples, go to PARITY.
  - PARITY: sample once at mid-bit. Expected value = ^byte for PARITY_BITS=1, ~^byte for PARITY_BITS=0. Go to STOP.
  - STOP: sample STOP_BITS times at mid-bit, then go to IDLE on the cycle after the last stop sample, so the next start edge is caught without a gap.
- Word assembly: byte k (k=0 is the first received) is written to tdata bits [AXI_DATA_WIDTH-1-k*DATA_BITS -: DATA_BITS] of an internal shadow register. count_byte increments after each good character.
- Error handling:
  - Parity mismatch: parity_err pulses on the cycle after the last stop sample.
  - Any low stop sample: frame_err pulses on the cycle after the last stop sample.
  - If both occur, both pulse in the same cycle.
  - On either error the partial word is discarded and count_byte resets to 0.
- Word completion (last stop sample of character DATA_BYTE-1, no errors):
  - If tvalid=0, or tvalid=1 and tready=1 in the same cycle: load tdata from shadow, set tvalid=1 and pulse rx_done on the next cycle.
  - Otherwise (tvalid=1, tready=0): drop the new word, pulse overrun, leave tdata/tvalid unchanged.
  - count_byte resets to 0 in all cases.
- AXI-Stream handshake: tvalid stays asserted and tdata stays stable until a cycle with tready=1. tvalid deasserts the cycle after the handshake unless a new word is loaded in that same cycle. tvalid never depends combinationally on tready.
- Width rules:
  - count_baud is $clog2(COUNT_SPEED) bits.
  - count_bit is $clog2(DATA_BITS) bits.
  - count_byte is max(1,$clog2(DATA_BYTE)) bits.
  - No counter wraps unintentionally.
  - DATA_BYTE=1 is legal: every good character produces a word.

Optional Feature:
Macro: UART_RX_TIMEOUT_EN.
- Defined: an idle counter runs in IDLE whenever count_byte != 0. If the line stays idle for 4*(DATA_BITS+2+STOP_BITS) bit times, the partial word is discarded, count_byte is cleared, and an extra output port timeout pulses for one cycle. This resynchronises after a lost character.
- Not defined: no timeout port and no idle counter; a partial word waits indefinitely for its remaining characters.

Test Plan:
- Default framing: CLOCK=1_000_000, BAUD_RATE=100_000, 32/8, even parity, 1 stop. Send 0xDE,0xAD,0xBE,0xEF back-to-back with tready=1 -> one rx_done pulse, tdata=0x DEADBEEF, tvalid high for exactly one cycle, no error pulses.
- Backpressure: tready=0, send two words 0x01020304 then 0xA5A5A5A5 -> first word held stable, overrun pulses once at the end of the second word, tdata stays 0x01020304. Raise tready -> handshake, then tvalid=0.
- Parity: send the second character 0xAD with parity bit inverted -> parity_err pulse, no rx_done. Then send a full 0x11223344 -> tdata=0x11223344.
- Framing and glitch: stop bit forced low on the first character -> frame_err pulse, word discarded. Separately, a 2-clock low glitch on an idle line -> stays IDLE, no outputs.
- Reset: assert aresetn=0 mid-way through the third character, then release -> all outputs 0, next 4 clean characters 0xCAFEF00D yield exactly that word. With UART_RX_TIMEOUT_EN defined, stopping after 2 characters -> timeout pulse, and the next 4 characters form a clean word.

Source files
------------

// File: rtl/axis_uart_rx.sv
// ---------------------------------------------------------------------------
// axis_uart_rx
//
// UART receiver that collects DATA_BYTE consecutive characters into one
// AXI-Stream word, most significant byte first. Each character is framed as:
// start bit, DATA_BITS data bits LSB first, one parity bit, STOP_BITS stop
// bits. This is the receive-side partner of the AXI-Stream UART transmitter.
//
// Ports:
//   aclk           clock
//   aresetn        synchronous active-low reset
//   uart_rx        asynchronous serial input, idle high
//   rx_done        one-cycle pulse when a new word is loaded into m_axis_tdata
//   parity_err     one-cycle pulse when a character fails its parity check
//   frame_err      one-cycle pulse when any stop bit is sampled low
//   overrun        one-cycle pulse when a finished word is dropped because the
//                  previous word has not been accepted yet
//   m_axis_tready  downstream ready
//   m_axis_tvalid  output word valid (registered)
//   m_axis_tdata   output word
//   timeout        (only with UART_RX_TIMEOUT_EN) one-cycle pulse when a
//                  partial word is discarded after a long idle line
//
// Optional feature macro: UART_RX_TIMEOUT_EN
//   Defined:   an idle counter discards a partial word after
//              4*(DATA_BITS+2+STOP_BITS) idle bit times and pulses timeout.
//   Undefined: no timeout port; a partial word waits indefinitely.
// ---------------------------------------------------------------------------
module axis_uart_rx #(
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_BITS    = 1,
    parameter int STOP_BITS      = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      uart_rx,
    output logic                      rx_done,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
    localparam int DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
    localparam int BAUD_W      = $clog2(COUNT_SPEED);
    localparam int BIT_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int BYTE_W      = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;

    localparam logic [BAUD_W-1:0] HALF_BIT  = BAUD_W'(COUNT_SPEED / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_BIT  = BAUD_W'(COUNT_SPEED - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    logic                      rx_meta;
    logic                      rx_sync;
    logic                      rx_prev;
    logic                      rx_fall;
    logic [BAUD_W-1:0]         count_baud;
    logic [BIT_W-1:0]          count_bit;
    logic [BYTE_W-1:0]         count_byte;
    logic [DATA_BITS-1:0]      shift_reg;
    logic [AXI_DATA_WIDTH-1:0] shadow;
    logic                      parity_bad;
    logic                      stop_low;
    logic                      parity_exp;
    logic                      stop_bad_now;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 4 * (DATA_BITS + 2 + STOP_BITS) * COUNT_SPEED;
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] count_idle;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // Reset to 1 so that a reset never looks like a start edge.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall      = rx_prev & ~rx_sync;
    assign parity_exp   = (PARITY_BITS == 1) ? ^shift_reg : ~^shift_reg;
    assign stop_bad_now = stop_low | ~rx_sync;

    // Receive FSM, word assembly and AXI-Stream output register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            count_baud    <= '0;
            count_bit     <= '0;
            count_byte    <= '0;
            shift_reg     <= '0;
            shadow        <= '0;
            parity_bad    <= 1'b0;
            stop_low      <= 1'b0;
            rx_done       <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
`ifdef UART_RX_TIMEOUT_EN
            count_idle    <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            timeout    <= 1'b0;
`endif

            // Handshake retires the word; a word completing in this same
            // cycle re-asserts tvalid further down and wins.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count_baud <= '0;
                    count_bit  <= '0;
                    if (rx_fall) begin
                        state <= START;
                    end
                end

                START: begin
                    if (count_baud == HALF_BIT) begin
                        count_baud <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                        end else begin
                            state      <= DATA;
                            parity_bad <= 1'b0;
                            stop_low   <= 1'b0;
                        end
                    end else begin
                        count_baud <= count_baud + 1'b1;
                    end
                end

                DATA: begin
                    if (count_baud == FULL_BIT) begin
                        count_baud           <= '0;
                        shift_reg[count_bit] <= rx_sync;
                        if (count_bit == LAST_DATA) begin
                            count_bit <= '0;
                            state     <= PARITY;
                        end else begin
                            count_bit <= count_bit + 1'b1;
                        end
                    end else begin
                        count_baud <= count_baud + 1'b1;
                    end
                end

                // The byte is parked in the shadow slot now; if the character
                // later proves bad, count_byte is cleared and the slot is
                // simply overwritten by the next word.
                PARITY: begin
                    if (count_baud == FULL_BIT) begin
                        count_baud <= '0;
                        parity_bad <= (rx_sync != parity_exp);
                        for (int k = 0; k < DATA_BYTE; k++) begin
                            if (count_byte == BYTE_W'(k)) begin
                                shadow[AXI_DATA_WIDTH-1-k*DATA_BITS -: DATA_BITS] <= shift_reg;
                            end
                        end
                        state <= STOP;
                    end else begin
                        count_baud <= count_baud + 1'b1;
                    end
                end

                STOP: begin
                    if (count_baud == FULL_BIT) begin
                        count_baud <= '0;
                        if (count_bit == LAST_STOP) begin
                            count_bit  <= '0;
                            state      <= IDLE;
                            parity_err <= parity_bad;
                            frame_err  <= stop_bad_now;
                            if (parity_bad || stop_bad_now) begin
                                count_byte <= '0;
                            end else if (count_byte == LAST_BYTE) begin
                                count_byte <= '0;
                                if (!m_axis_tvalid || m_axis_tready) begin
                                    m_axis_tdata  <= shadow;
                                    m_axis_tvalid <= 1'b1;
                                    rx_done       <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                count_byte <= count_byte + 1'b1;
                            end
                        end else begin
                            count_bit <= count_bit + 1'b1;
                            stop_low  <= stop_bad_now;
                        end
                    end else begin
                        count_baud <= count_baud + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef UART_RX_TIMEOUT_EN
            // Only a partial word in IDLE with no new start edge ages.
            if (state == IDLE && count_byte != '0 && !rx_fall) begin
                if (count_idle == IDLE_LAST) begin
                    count_idle <= '0;
                    count_byte <= '0;
                    timeout    <= 1'b1;
                end else begin
                    count_idle <= count_idle + 1'b1;
                end
            end else begin
                count_idle <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_axis_uart_rx
//
// Self-checking bench for axis_uart_rx at 1 MHz / 100 kBd (10 clocks per
// bit), 32-bit words of 8-bit characters, even parity, one stop bit.
// A monitor counts every output pulse and records each delivered word; the
// directed sequence compares those against values derived from the frame
// rules. A randomized section feeds characters (some corrupted) and compares
// delivered words against a byte-queue reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_uart_rx;

    localparam int CLOCK    = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int W        = 32;
    localparam int DB       = 8;
    localparam int BIT_CLKS = CLOCK / BAUD;

    logic         aclk    = 1'b0;
    logic         aresetn = 1'b0;
    logic         uart_rx = 1'b1;
    logic         tready  = 1'b1;
    logic         rx_done;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         tvalid;
    logic [W-1:0] tdata;
`ifdef UART_RX_TIMEOUT_EN
    logic         timeout;
`endif

    int checks  = 0;
    int errors  = 0;
    int n_done  = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_tmo   = 0;
    int n_valid = 0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] got_q[$];

    axis_uart_rx #(
        .CLOCK          (CLOCK),
        .BAUD_RATE      (BAUD),
        .AXI_DATA_WIDTH (W),
        .DATA_BITS      (DB),
        .PARITY_BITS    (1),
        .STOP_BITS      (1)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .uart_rx       (uart_rx),
        .rx_done       (rx_done),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .m_axis_tready (tready),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata)
`ifdef UART_RX_TIMEOUT_EN
        ,
        .timeout       (timeout)
`endif
    );

    always #5 aclk = ~aclk;

    // Monitor: counts pulse cycles and captures delivered words.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (rx_done) begin
                n_done++;
                last_word = tdata;
                got_q.push_back(tdata);
            end
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (tvalid)     n_valid++;
`ifdef UART_RX_TIMEOUT_EN
            if (timeout)    n_tmo++;
`endif
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge aclk);
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (BIT_CLKS) @(negedge aclk);
    endtask

    // Drives the first n_bits bit periods of a frame; a low stop bit is
    // followed by one idle bit so the next start edge is visible.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit low_stop, input int n_bits);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = (($countones(d) % 2) == 1) ^ bad_par;
        f[10]  = ~low_stop;
        for (int i = 0; i < n_bits; i++) bit_time(f[i]);
        if (low_stop) bit_time(1'b1);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < W / DB; k++) send_frame(w[W-1-k*DB -: DB], 1'b0, 1'b0, 11);
    endtask

    initial begin
        int d0;
        int v0;
        int e0;
        logic [W-1:0] w;
        logic [7:0] pending[$];
        logic [W-1:0] exp_q[$];
        int exp_perr;
        int exp_ferr;

        // Reset state
        aresetn = 1'b0;
        repeat (5) @(negedge aclk);
        check_output("reset_tvalid", W'(tvalid), '0);
        check_output("reset_tdata", tdata, '0);
        check_output("reset_pulses", W'({rx_done, parity_err, frame_err, overrun}), '0);
        aresetn = 1'b1;
        idle(20);

        // Back-to-back word with tready high
        $display("[TB] word DEADBEEF");
        d0 = n_done; v0 = n_valid; e0 = n_perr + n_ferr + n_ovr;
        send_word(32'hDEADBEEF);
        idle(30);
        check_output("deadbeef_done", W'(n_done - d0), 1);
        check_output("deadbeef_word", last_word, 32'hDEADBEEF);
        check_output("deadbeef_valid_cycles", W'(n_valid - v0), 1);
        check_output("deadbeef_no_err", W'(n_perr + n_ferr + n_ovr - e0), 0);

        // Backpressure and overrun
        $display("[TB] backpressure");
        tready = 1'b0;
        d0 = n_done;
        send_word(32'h01020304);
        idle(20);
        check_output("bp_done", W'(n_done - d0), 1);
        check_output("bp_tvalid", W'(tvalid), 1);
        e0 = n_ovr;
        send_word(32'hA5A5A5A5);
        idle(20);
        check_output("bp_overrun", W'(n_ovr - e0), 1);
        check_output("bp_tdata_held", tdata, 32'h01020304);
        check_output("bp_no_new_done", W'(n_done - d0), 1);
        tready = 1'b1;
        @(negedge aclk);
        check_output("bp_tvalid_after_hs", W'(tvalid), 0);
        idle(10);

        // Parity error on the second character
        $display("[TB] parity");
        d0 = n_done; e0 = n_perr;
        send_frame(8'hDE, 1'b0, 1'b0, 11);
        send_frame(8'hAD, 1'b1, 1'b0, 11);
        idle(30);
        check_output("par_err", W'(n_perr - e0), 1);
        check_output("par_no_done", W'(n_done - d0), 0);
        send_word(32'h11223344);
        idle(30);
        check_output("par_recover_word", last_word, 32'h11223344);
        check_output("par_recover_done", W'(n_done - d0), 1);

        // Framing error on the first character
        $display("[TB] framing");
        e0 = n_ferr;
        send_frame(8'($urandom), 1'b0, 1'b1, 11);
        idle(30);
        check_output("frame_err", W'(n_ferr - e0), 1);
        d0 = n_done;
        w = $urandom;
        send_word(w);
        idle(30);
        check_output("frame_recover_word", last_word, w);
        check_output("frame_recover_done", W'(n_done - d0), 1);

        // Two-clock glitch between characters leaves the byte count intact
        $display("[TB] glitch");
        d0 = n_done; e0 = n_perr + n_ferr + n_ovr;
        w = $urandom;
        send_frame(w[31:24], 1'b0, 1'b0, 11);
        send_frame(w[23:16], 1'b0, 1'b0, 11);
        idle(5);
        uart_rx = 1'b0;
        repeat (2) @(negedge aclk);
        idle(30);
        check_output("glitch_silent", W'(n_done - d0 + n_perr + n_ferr + n_ovr - e0), 0);
        send_frame(w[15:8], 1'b0, 1'b0, 11);
        send_frame(w[7:0], 1'b0, 1'b0, 11);
        idle(30);
        check_output("glitch_word", last_word, w);
        check_output("glitch_done", W'(n_done - d0), 1);

        // Reset in the middle of the third character with a word pending
        $display("[TB] reset mid-frame");
        tready = 1'b0;
        send_word($urandom);
        idle(20);
        check_output("rst_pre_tvalid", W'(tvalid), 1);
        send_frame(8'h12, 1'b0, 1'b0, 11);
        send_frame(8'h34, 1'b0, 1'b0, 11);
        send_frame(8'h56, 1'b0, 1'b0, 5);
        uart_rx = 1'b1;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_output("rst_tvalid", W'(tvalid), 0);
        check_output("rst_tdata", tdata, '0);
        check_output("rst_pulses", W'({rx_done, parity_err, frame_err, overrun}), '0);
        aresetn = 1'b1;
        tready = 1'b1;
        idle(20);
        d0 = n_done;
        send_word(32'hCAFEF00D);
        idle(30);
        check_output("rst_clean_word", last_word, 32'hCAFEF00D);
        check_output("rst_clean_done", W'(n_done - d0), 1);

        // Randomized characters against a byte-queue reference model
        $display("[TB] random");
        got_q.delete();
        exp_perr = n_perr;
        exp_ferr = n_ferr;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] c;
            bit bp;
            bit bs;
            c  = 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 9) == 0);
            send_frame(c, bp, bs, 11);
            idle($urandom_range(0, 2) * BIT_CLKS);
            if (bp) exp_perr++;
            if (bs) exp_ferr++;
            if (bp || bs) begin
                pending.delete();
            end else begin
                pending.push_back(c);
                if (pending.size() == W / DB) begin
                    exp_q.push_back({pending[0], pending[1], pending[2], pending[3]});
                    pending.delete();
                end
            end
        end
        idle(30);
        check_output("rand_word_count", W'(got_q.size()), W'(exp_q.size()));
        check_output("rand_perr", W'(n_perr), W'(exp_perr));
        check_output("rand_ferr", W'(n_ferr), W'(exp_ferr));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_output($sformatf("rand_word%0d", i), got_q[i], exp_q[i]);
        end

`ifdef UART_RX_TIMEOUT_EN
        // Partial word abandoned on an idle line
        $display("[TB] timeout");
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        idle(10);
        e0 = n_tmo;
        send_frame(8'h77, 1'b0, 1'b0, 11);
        send_frame(8'h88, 1'b0, 1'b0, 11);
        idle(50 * BIT_CLKS);
        check_output("tmo_pulse", W'(n_tmo - e0), 1);
        d0 = n_done;
        w = $urandom;
        send_word(w);
        idle(30);
        check_output("tmo_clean_word", last_word, w);
        check_output("tmo_clean_done", W'(n_done - d0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
